ctrl_seq: RTL
=============

# ctrl_seq

Multi-cycle instruction sequencer for the mycpu datapath. It fetches 16-bit instructions from instruction memory over a req/ack handshake, decodes them, and issues the function select, register addresses and write enable to the register file and function unit. It consumes the function unit's zero/negative flags for conditional branches. It is the control-side counterpart of the function unit: it generates `fs` and reads back `z`/`n`.

## Interface
- No parameters; all widths are fixed by mycpu_pkg.
- `clk`  in  1  system clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request; held high until acknowledged.
- `imem_addr`  out  8  fetch address, equal to the PC.
- `imem_ack`  in  1  one-cycle acknowledge; `imem_data` is valid in the same cycle.
- `imem_data`  in  16  instruction word.
- `fs_out`  out  4  function select (fs_t) to the function unit.
- `aa_out`, `ba_out`, `da_out`  out  3 each  register-file A, B and destination addresses.
- `mb_sel`  out  1  selects `imm_out` instead of register B as the FU B operand.
- `imm_out`  out  16  zero-extended immediate.
- `rw_out`  out  1  register-file write enable.
- `z_in`, `n_in`  in  1 each  FU flags, valid in the same cycle as `fs_out`.
- `pc_out`  out  8  current PC.
- `halt_out`  out  1  sequencer halted.
- `err_out`  out  1  halt was caused by an illegal opcode.

## Operation
- Instruction fields: [15:13] class, [12:9] fs, [8:6] dr, [5:3] sa, [2:0] sb/imm3; [7:0] is the branch target.
- Class 000 (ALU reg): FU op `fs` on R[sa], R[sb]; result written to R[dr].
- Class 001 (ALU imm): same as class 000, but B operand is `imm_out` = {13'b0, imm3} and `mb_sel`=1.
- Class 010 (BRZ): if Z flag = 1, PC ← [7:0]; otherwise PC+1.
- Class 011 (BRN): same as BRZ, using the N flag.
- Class 100 (JMP): PC ← [7:0] unconditionally.
- Class 111 (HALT): go to HALTED with `err_out`=0.
- Classes 101 and 110 are illegal: go to HALTED with `err_out`=1.
- Z/N flag registers load `z_in`/`n_in` only in EXEC. Branches use the flags from the most recent ALU instruction.
- FSM states: FETCH, DECODE, EXEC, HALTED.
  - FETCH → DECODE when `imem_ack` is sampled high; IR ← `imem_data`.
  - DECODE → EXEC for ALU classes.
  - DECODE → FETCH for branch and jump; PC is updated in this cycle.
  - DECODE → HALTED for HALT and illegal classes.
  - EXEC → FETCH; PC ← PC+1.
  - HALTED is absorbing; only reset leaves it.
- PC arithmetic is 8-bit modulo: 0xFF+1 wraps to 0x00.
- Outputs outside EXEC: `fs_out`=MOVA, `rw_out`=0, `mb_sel`=0. Address outputs hold IR fields.

## Timing
- Reset values: state FETCH, PC 0x00, IR 0x0000, Z=0, N=0, `imem_req`=0, `rw_out`=0, `fs_out`=MOVA, `mb_sel`=0, `imm_out`=0, `halt_out`=0, `err_out`=0.
- `imem_req` rises in the first cycle after reset deasserts. `imem_req` and `imem_addr` are registered outputs.
- `imem_req` and `imem_addr` stay stable until `imem_ack`. `imem_req` drops in the cycle after ack.
- `imem_ack` with `imem_req` low is ignored.
- With zero wait states:
  - ALU instruction: 3 cycles (FETCH, DECODE, EXEC).
  - Branch/jump: 2 cycles.
- `rw_out` is high for exactly one cycle per ALU instruction. `fs_out`, addresses, `mb_sel` and `imm_out` are valid in that same cycle.
- `halt_out` rises the cycle after DECODE of HALT or an illegal class. `imem_req` stays 0 thereafter.
- Reset asserted mid-fetch drops `imem_req` immediately (asynchronous). A late ack after reset is ignored.

## Structure
- Add to mycpu_pkg:
  - `state_t` for the FSM states.
  - `iclass_t` with the class encodings.
  - field-position constants for the instruction word.
  - reuse the existing `fs_t`.
- One natural sub-module: `ctrl_decode`, combinational, IR → class / fs / addresses / immediate / legal.
- The FSM, PC, IR and flag registers stay in `ctrl_seq`.

## Test plan
- Reset, then IR 0x0000 (ALU reg, MOVA, R0←R0) acked with zero wait → `rw_out` high in cycle 3 with `fs_out`=0; PC=0x01; `imem_req` high again in cycle 4.
- ALU imm word 0x24D5 (fs=FADD, dr=3, sa=2, imm=5) → EXEC shows `fs_out`=0010, `da_out`=3, `aa_out`=2, `mb_sel`=1, `imm_out`=0x0005.
- Class 0 ALU op executed with `z_in`=1, followed by BRZ 0x4040 → PC=0x40. Repeat with `z_in`=0 → PC advances by 1.
- JMP 0x80FF followed by any 1-cycle ALU op → PC wraps from 0xFF to 0x00.
- Ack delayed 5 cycles → `imem_req`/`imem_addr` held constant throughout; no `rw_out` pulse before ack. Spurious ack while `imem_req` low → no state change.
- Word 0xA000 → `halt_out`=1, `err_out`=1, `imem_req` stays 0. Word 0xE000 → `halt_out`=1, `err_out`=0. `rst_n` low during a pending fetch → `imem_req`=0 immediately, PC=0x00.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared types and constants for the mycpu datapath and its instruction sequencer.
package mycpu_pkg;

    typedef enum logic [3:0] {
        FS_MOVA  = 4'h0,
        FS_INC   = 4'h1,
        FS_FADD  = 4'h2,
        FS_FADDC = 4'h3,
        FS_FSUBB = 4'h4,
        FS_FSUB  = 4'h5,
        FS_DEC   = 4'h6,
        FS_TFRA  = 4'h7,
        FS_AND   = 4'h8,
        FS_OR    = 4'h9,
        FS_XOR   = 4'hA,
        FS_NOT   = 4'hB,
        FS_MOVB  = 4'hC,
        FS_SHR   = 4'hD,
        FS_SHL   = 4'hE,
        FS_RSVD  = 4'hF
    } fs_t;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALTED
    } state_t;

    // Classes 101 and 110 are named only so any 3-bit field casts cleanly.
    typedef enum logic [2:0] {
        IC_ALU_REG = 3'b000,
        IC_ALU_IMM = 3'b001,
        IC_BRZ     = 3'b010,
        IC_BRN     = 3'b011,
        IC_JMP     = 3'b100,
        IC_ILL5    = 3'b101,
        IC_ILL6    = 3'b110,
        IC_HALT    = 3'b111
    } iclass_t;

    localparam int CLS_HI = 15;
    localparam int CLS_LO = 13;
    localparam int FS_HI  = 12;
    localparam int FS_LO  = 9;
    localparam int DR_HI  = 8;
    localparam int DR_LO  = 6;
    localparam int SA_HI  = 5;
    localparam int SA_LO  = 3;
    localparam int SB_HI  = 2;
    localparam int SB_LO  = 0;
    localparam int TGT_HI = 7;
    localparam int TGT_LO = 0;

    function automatic logic classLegal(input iclass_t c);
        return !((c == IC_ILL5) || (c == IC_ILL6));
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: splits the instruction register into
// class, function select, register addresses, immediate and branch target.
module ctrl_decode
    import mycpu_pkg::*;
(
    input  logic [15:0] ir_i,
    output iclass_t     iclass_o,
    output fs_t         fs_o,
    output logic [2:0]  da_o,
    output logic [2:0]  aa_o,
    output logic [2:0]  ba_o,
    output logic [15:0] imm_o,
    output logic [7:0]  target_o,
    output logic        legal_o
);

    assign iclass_o = iclass_t'(ir_i[CLS_HI:CLS_LO]);
    assign fs_o     = fs_t'(ir_i[FS_HI:FS_LO]);
    assign da_o     = ir_i[DR_HI:DR_LO];
    assign aa_o     = ir_i[SA_HI:SA_LO];
    assign ba_o     = ir_i[SB_HI:SB_LO];
    assign imm_o    = {13'b0, ir_i[SB_HI:SB_LO]};
    assign target_o = ir_i[TGT_HI:TGT_LO];
    assign legal_o  = classLegal(iclass_o);

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer: fetches over a req/ack handshake, decodes,
// and drives register-file / function-unit controls; owns PC, IR and Z/N flags.
module ctrl_seq
    import mycpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [3:0]  fs_out,
    output logic [2:0]  aa_out,
    output logic [2:0]  ba_out,
    output logic [2:0]  da_out,
    output logic        mb_sel,
    output logic [15:0] imm_out,
    output logic        rw_out,
    input  logic        z_in,
    input  logic        n_in,
    output logic [7:0]  pc_out,
    output logic        halt_out,
    output logic        err_out
);

    state_t      state_q;
    logic [7:0]  pc_q;
    logic [15:0] ir_q;
    logic        zFlag_q;
    logic        nFlag_q;
    logic        memReq_q;
    logic        rwEn_q;
    logic        mbSel_q;
    fs_t         fsSel_q;
    logic        halt_q;
    logic        err_q;

    iclass_t     decClass;
    fs_t         decFs;
    logic [2:0]  decDa;
    logic [2:0]  decAa;
    logic [2:0]  decBa;
    logic [15:0] decImm;
    logic [7:0]  decTarget;
    logic        decLegal;

    logic [7:0]  pcInc_d;
    logic        branchTaken_d;
    logic [7:0]  pcBranch_d;

    ctrl_decode u_decode (
        .ir_i     (ir_q),
        .iclass_o (decClass),
        .fs_o     (decFs),
        .da_o     (decDa),
        .aa_o     (decAa),
        .ba_o     (decBa),
        .imm_o    (decImm),
        .target_o (decTarget),
        .legal_o  (decLegal)
    );

    assign pcInc_d = pc_q + 8'd1;

    // Branches consult the flags latched by the most recent ALU instruction.
    always_comb begin
        branchTaken_d = 1'b0;
        case (decClass)
            IC_BRZ:  branchTaken_d = zFlag_q;
            IC_BRN:  branchTaken_d = nFlag_q;
            IC_JMP:  branchTaken_d = 1'b1;
            default: branchTaken_d = 1'b0;
        endcase
        pcBranch_d = branchTaken_d ? decTarget : pcInc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= 8'h00;
            ir_q     <= 16'h0000;
            zFlag_q  <= 1'b0;
            nFlag_q  <= 1'b0;
            memReq_q <= 1'b0;
            rwEn_q   <= 1'b0;
            mbSel_q  <= 1'b0;
            fsSel_q  <= FS_MOVA;
            halt_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    // Only the first fetch after reset finds the request low here.
                    if (!memReq_q) begin
                        memReq_q <= 1'b1;
                    end else if (imem_ack) begin
                        ir_q     <= imem_data;
                        memReq_q <= 1'b0;
                        state_q  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (decClass)
                        IC_ALU_REG, IC_ALU_IMM: begin
                            rwEn_q  <= 1'b1;
                            fsSel_q <= decFs;
                            mbSel_q <= (decClass == IC_ALU_IMM);
                            state_q <= ST_EXEC;
                        end
                        IC_BRZ, IC_BRN, IC_JMP: begin
                            pc_q     <= pcBranch_d;
                            memReq_q <= 1'b1;
                            state_q  <= ST_FETCH;
                        end
                        default: begin
                            halt_q  <= 1'b1;
                            err_q   <= !decLegal;
                            state_q <= ST_HALTED;
                        end
                    endcase
                end
                ST_EXEC: begin
                    zFlag_q  <= z_in;
                    nFlag_q  <= n_in;
                    pc_q     <= pcInc_d;
                    rwEn_q   <= 1'b0;
                    fsSel_q  <= FS_MOVA;
                    mbSel_q  <= 1'b0;
                    memReq_q <= 1'b1;
                    state_q  <= ST_FETCH;
                end
                default: begin
                    state_q <= ST_HALTED;
                end
            endcase
        end
    end

    assign imem_req  = memReq_q;
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign fs_out    = fsSel_q;
    assign rw_out    = rwEn_q;
    assign mb_sel    = mbSel_q;
    assign aa_out    = decAa;
    assign ba_out    = decBa;
    assign da_out    = decDa;
    assign imm_out   = decImm;
    assign halt_out  = halt_q;
    assign err_out   = err_q;

endmodule
